// File: rtl/pipeline_ctrl.sv
// Main controller for the 8-bit 5-stage pipeline: ID decode, ID/EX -> EX/MEM -> MEM/WB
// control pipeline, load-use stall, mispredict/jump flush and HALT drain sequencing.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction_IF,
  input  logic        mispredict_EX,
  output logic        stall,
  output logic        flush,
  output logic        jump,
  output logic        PC_sel,
  output logic [1:0]  ImmSrc,
  output logic        ALUsrc,
  output logic [3:0]  opcode,
  output logic        dir,
  output logic        MemRead_MEM,
  output logic        MemWrite_MEM,
  output logic        RegWrite_MEM,
  output logic        ResultSrc_MEM,
  output logic        RegWrite_WB,
  output logic        halted
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       result_src;
    logic [2:0] rd;
  } ctrl_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  ctrl_t          id_ex, ex_mem, dec;
  logic           mem_wb_rw;

  logic [3:0] op;
  logic [2:0] rs1, rs2;
  logic       rd_rs1, rd_rs2, is_halt, load_use;

  assign op  = instruction_IF[15:12];
  assign rs1 = instruction_IF[8:6];
  assign rs2 = instruction_IF[5:3];

  always_comb begin
    ImmSrc   = 2'b00;
    ALUsrc   = 1'b0;
    opcode   = 4'h0;
    jump     = 1'b0;
    rd_rs1   = 1'b0;
    rd_rs2   = 1'b0;
    dec      = '0;
    dec.rd   = instruction_IF[11:9];
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        opcode = op; rd_rs1 = 1'b1; rd_rs2 = 1'b1; dec.reg_write = 1'b1;
      end
      4'h6: begin
        opcode = op; rd_rs1 = 1'b1; dec.reg_write = 1'b1;
      end
      4'h7: begin
        ALUsrc = 1'b1; opcode = 4'h1; rd_rs1 = 1'b1; dec.reg_write = 1'b1;
      end
      4'h8: begin
        ALUsrc = 1'b1; opcode = 4'h1; rd_rs1 = 1'b1;
        dec.mem_read = 1'b1; dec.reg_write = 1'b1; dec.result_src = 1'b1;
      end
      4'h9: begin
        ImmSrc = 2'b01; ALUsrc = 1'b1; opcode = 4'h1; rd_rs1 = 1'b1; rd_rs2 = 1'b1;
        dec.mem_write = 1'b1;
      end
      4'hA, 4'hB: begin
        ImmSrc = 2'b10; opcode = 4'h2; rd_rs1 = 1'b1; rd_rs2 = 1'b1;
      end
      4'hC: jump = 1'b1;
      default: ;
    endcase
  end

  assign dir     = instruction_IF[0];
  assign PC_sel  = jump;
  assign is_halt = (op == 4'hF);

  // x0 is never a real producer, so a load into r0 cannot cause a hazard
  assign load_use = id_ex.mem_read && (id_ex.rd != 3'd0) &&
                    ((rd_rs1 && rs1 == id_ex.rd) || (rd_rs2 && rs2 == id_ex.rd));

  // JMP only squashes while running; once draining the ID slot is frozen behind HALT
  assign flush = !reset && (mispredict_EX || (state == RUN && jump));
  assign stall = !reset && !flush && (state != RUN || load_use || is_halt);

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex     <= '0;
      ex_mem    <= '0;
      mem_wb_rw <= 1'b0;
      state     <= RUN;
      cnt       <= '0;
      halted    <= 1'b0;
    end else begin
      id_ex     <= (flush || stall) ? ctrl_t'('0) : dec;
      ex_mem    <= id_ex;
      mem_wb_rw <= ex_mem.reg_write;
      case (state)
        RUN: if (!flush && is_halt) begin
          // the HALT decode cycle is drain count 0
          state <= DRAIN;
          cnt   <= CW'(1);
        end
        DRAIN: begin
          if (mispredict_EX) begin
            state <= RUN;
            cnt   <= '0;
          end else if (cnt == CW'(DRAIN_CYCLES - 1)) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign MemRead_MEM   = ex_mem.mem_read;
  assign MemWrite_MEM  = ex_mem.mem_write;
  assign RegWrite_MEM  = ex_mem.reg_write;
  assign ResultSrc_MEM = ex_mem.result_src;
  assign RegWrite_WB   = mem_wb_rw;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus a random run against a stage-occupancy model.
module tb_pipeline_ctrl;
  localparam int DRAIN = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction_IF;
  logic        mispredict_EX;
  logic        stall, flush, jump, PC_sel, ALUsrc, dir;
  logic [1:0]  ImmSrc;
  logic [3:0]  opcode;
  logic        MemRead_MEM, MemWrite_MEM, RegWrite_MEM, ResultSrc_MEM, RegWrite_WB, halted;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset), .instruction_IF(instruction_IF), .mispredict_EX(mispredict_EX),
    .stall(stall), .flush(flush), .jump(jump), .PC_sel(PC_sel), .ImmSrc(ImmSrc),
    .ALUsrc(ALUsrc), .opcode(opcode), .dir(dir), .MemRead_MEM(MemRead_MEM),
    .MemWrite_MEM(MemWrite_MEM), .RegWrite_MEM(RegWrite_MEM), .ResultSrc_MEM(ResultSrc_MEM),
    .RegWrite_WB(RegWrite_WB), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1; instruction_IF = 16'h0; mispredict_EX = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // {MemRead, MemWrite, RegWrite, ResultSrc}_MEM, RegWrite_WB, halted
  function automatic logic [5:0] back_bits();
    return {MemRead_MEM, MemWrite_MEM, RegWrite_MEM, ResultSrc_MEM, RegWrite_WB, halted};
  endfunction

  task automatic test_reset;
    do_reset();
    instruction_IF = 16'h1283; tick();
    instruction_IF = 16'h0;    tick();
    reset = 1'b1; instruction_IF = 16'h9000; mispredict_EX = 1'b1; #1;
    n_checks++;
    if ({stall, flush} !== 2'b00) begin
      n_fail++; $display("FAIL reset_sf: got %b want 00", {stall, flush});
    end
    n_checks++;
    if ({ImmSrc, ALUsrc, opcode} !== {2'b01, 1'b1, 4'h1}) begin
      n_fail++; $display("FAIL reset_decode: got %b want %b", {ImmSrc, ALUsrc, opcode}, {2'b01, 1'b1, 4'h1});
    end
    tick();
    n_checks++;
    if (back_bits() !== 6'b0) begin
      n_fail++; $display("FAIL reset_regs: got %b want 000000", back_bits());
    end
    reset = 1'b0; mispredict_EX = 1'b0; instruction_IF = 16'h0;
    tick();
    n_checks++;
    if (RegWrite_WB !== 1'b0) begin
      n_fail++; $display("FAIL reset_wb: got %b want 0", RegWrite_WB);
    end
  endtask

  task automatic test_add;
    do_reset();
    instruction_IF = 16'h1283; #1;
    n_checks++;
    if ({ImmSrc, ALUsrc, opcode, stall, flush} !== {2'b00, 1'b0, 4'h1, 2'b00}) begin
      n_fail++; $display("FAIL add_decode: got %b want %b", {ImmSrc, ALUsrc, opcode, stall, flush}, {2'b00, 1'b0, 4'h1, 2'b00});
    end
    tick(); instruction_IF = 16'h0; #1;
    n_checks++;
    if ({RegWrite_MEM, stall, flush} !== 3'b000) begin
      n_fail++; $display("FAIL add_edge1: got %b want 000", {RegWrite_MEM, stall, flush});
    end
    tick();
    n_checks++;
    if ({RegWrite_MEM, RegWrite_WB, stall, flush} !== 4'b1000) begin
      n_fail++; $display("FAIL add_edge2: got %b want 1000", {RegWrite_MEM, RegWrite_WB, stall, flush});
    end
    tick();
    n_checks++;
    if ({RegWrite_WB, stall, flush} !== 3'b100) begin
      n_fail++; $display("FAIL add_edge3: got %b want 100", {RegWrite_WB, stall, flush});
    end
  endtask

  task automatic test_load_use;
    do_reset();
    instruction_IF = 16'h8400; tick();
    instruction_IF = 16'h1688; #1;
    n_checks++;
    if ({stall, flush} !== 2'b10) begin
      n_fail++; $display("FAIL lu_stall: got %b want 10", {stall, flush});
    end
    tick();
    n_checks++;
    if ({stall, MemRead_MEM, RegWrite_MEM} !== 3'b011) begin
      n_fail++; $display("FAIL lu_load_mem: got %b want 011", {stall, MemRead_MEM, RegWrite_MEM});
    end
    tick(); instruction_IF = 16'h0;
    n_checks++;
    if (back_bits() !== 6'b000010) begin
      n_fail++; $display("FAIL lu_bubble: got %b want 000010", back_bits());
    end
    tick();
    n_checks++;
    if (back_bits() !== 6'b001000) begin
      n_fail++; $display("FAIL lu_add_mem: got %b want 001000", back_bits());
    end
  endtask

  task automatic test_load_r0;
    do_reset();
    instruction_IF = 16'h8000; tick();
    instruction_IF = 16'h1608; #1;
    n_checks++;
    if ({stall, flush} !== 2'b00) begin
      n_fail++; $display("FAIL r0_nostall: got %b want 00", {stall, flush});
    end
  endtask

  task automatic test_mispredict;
    do_reset();
    instruction_IF = 16'h8400; tick();
    instruction_IF = 16'h1688; mispredict_EX = 1'b1; #1;
    n_checks++;
    if ({stall, flush} !== 2'b01) begin
      n_fail++; $display("FAIL mp_prio: got %b want 01", {stall, flush});
    end
    tick(); mispredict_EX = 1'b0; instruction_IF = 16'h0;
    n_checks++;
    if ({MemRead_MEM, RegWrite_MEM} !== 2'b11) begin
      n_fail++; $display("FAIL mp_exmem: got %b want 11", {MemRead_MEM, RegWrite_MEM});
    end
    tick();
    n_checks++;
    if (back_bits() !== 6'b000010) begin
      n_fail++; $display("FAIL mp_idex_zero: got %b want 000010", back_bits());
    end
  endtask

  task automatic test_halt;
    do_reset();
    instruction_IF = 16'hF000; #1;
    n_checks++;
    if ({stall, flush, halted} !== 3'b100) begin
      n_fail++; $display("FAIL halt_decode: got %b want 100", {stall, flush, halted});
    end
    for (int c = 1; c <= DRAIN + 2; c++) begin
      tick();
      n_checks++;
      if ({stall, halted} !== {1'b1, (c >= DRAIN)}) begin
        n_fail++; $display("FAIL halt_cycle%0d: got %b want %b", c, {stall, halted}, {1'b1, (c >= DRAIN)});
      end
    end
    reset = 1'b1; tick(); reset = 1'b0; instruction_IF = 16'h0; #1;
    n_checks++;
    if ({stall, halted} !== 2'b00) begin
      n_fail++; $display("FAIL halt_reset: got %b want 00", {stall, halted});
    end
    // mispredict from an older branch aborts the drain
    instruction_IF = 16'hF000; tick();
    mispredict_EX = 1'b1; #1;
    n_checks++;
    if ({stall, flush} !== 2'b01) begin
      n_fail++; $display("FAIL halt_abort_flush: got %b want 01", {stall, flush});
    end
    tick(); mispredict_EX = 1'b0; instruction_IF = 16'h0; #1;
    n_checks++;
    if ({stall, flush, halted} !== 3'b000) begin
      n_fail++; $display("FAIL halt_abort_run: got %b want 000", {stall, flush, halted});
    end
  endtask

  task automatic test_jmp;
    do_reset();
    instruction_IF = 16'hC000; #1;
    n_checks++;
    if ({jump, PC_sel, flush, stall} !== 4'b1110) begin
      n_fail++; $display("FAIL jmp_decode: got %b want 1110", {jump, PC_sel, flush, stall});
    end
    tick(); instruction_IF = 16'h0; #1;
    n_checks++;
    if ({jump, PC_sel, flush} !== 3'b000) begin
      n_fail++; $display("FAIL jmp_oneshot: got %b want 000", {jump, PC_sel, flush});
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({RegWrite_MEM, RegWrite_WB} !== 2'b00) begin
        n_fail++; $display("FAIL jmp_nowrite%0d: got %b want 00", c, {RegWrite_MEM, RegWrite_WB});
      end
      tick();
    end
  endtask

  // Model: instruction word occupying EX, MEM and WB (0 = bubble), plus edges since HALT decode.
  function automatic bit writes(logic [15:0] i);
    return i[15:12] >= 4'h1 && i[15:12] <= 4'h8;
  endfunction
  function automatic bit reads1(logic [3:0] o);
    return (o >= 4'h1 && o <= 4'h9) || o == 4'hA || o == 4'hB;
  endfunction
  function automatic bit reads2(logic [3:0] o);
    return (o >= 4'h1 && o <= 4'h5) || o == 4'h9 || o == 4'hA || o == 4'hB;
  endfunction

  task automatic test_random;
    logic [15:0] ex_i, mem_i, wb_i, ins;
    logic [3:0]  op;
    logic [2:0]  lrd;
    int          halt_age, halted_for, r;
    bit          misp, rst, e_flush, e_stall, hz, e_jump;
    logic [1:0]  e_imm;
    logic [10:0] exp_v;
    do_reset();
    ex_i = 0; mem_i = 0; wb_i = 0; halt_age = 0; halted_for = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      r = $urandom_range(0, 99);
      if (r < 25)      op = 4'h8;
      else if (r < 28) op = 4'hF;
      else if (r < 33) op = 4'hC;
      else             op = 4'($urandom_range(0, 14));
      ins = {op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom)};
      misp = ($urandom_range(0, 14) == 0);
      rst  = (halted_for >= 3) || ($urandom_range(0, 149) == 0);
      reset = rst; instruction_IF = ins; mispredict_EX = misp;
      #1;
      lrd     = ex_i[11:9];
      hz      = (ex_i[15:12] == 4'h8) && lrd != 0 &&
                ((reads1(op) && ins[8:6] == lrd) || (reads2(op) && ins[5:3] == lrd));
      e_flush = !rst && (misp || (halt_age == 0 && op == 4'hC));
      e_stall = !rst && !e_flush && (halt_age > 0 || hz || op == 4'hF);
      e_jump  = (op == 4'hC);
      e_imm   = (op == 4'h9) ? 2'b01 : (op == 4'hA || op == 4'hB) ? 2'b10 : 2'b00;
      exp_v = {e_stall, e_flush, e_jump, e_imm,
               mem_i[15:12] == 4'h8, mem_i[15:12] == 4'h9, writes(mem_i), mem_i[15:12] == 4'h8,
               writes(wb_i), halt_age >= DRAIN};
      n_checks++;
      if ({stall, flush, jump, ImmSrc, back_bits()} !== exp_v) begin
        n_fail++; $display("FAIL rand_cyc%0d ins=%h: got %b want %b", cyc, ins, {stall, flush, jump, ImmSrc, back_bits()}, exp_v);
      end
      @(posedge clk);
      if (rst) begin
        ex_i = 0; mem_i = 0; wb_i = 0; halt_age = 0;
      end else begin
        wb_i  = mem_i;
        mem_i = ex_i;
        ex_i  = (e_flush || e_stall) ? 16'h0 : ins;
        if (halt_age == 0) begin
          if (!e_flush && op == 4'hF) halt_age = 1;
        end else if (halt_age < DRAIN) begin
          halt_age = misp ? 0 : halt_age + 1;
        end
      end
      halted_for = (halt_age >= DRAIN) ? halted_for + 1 : 0;
      @(negedge clk);
    end
    reset = 1'b0; mispredict_EX = 1'b0;
  endtask

  initial begin
    reset = 1'b1; instruction_IF = 16'h0; mispredict_EX = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_load_use();
    test_load_r0();
    test_mispredict();
    test_halt();
    test_jmp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
